// File: rtl/cnn16_mem_unit.sv
// Single-port data/program memory for the CNN16 core: core reads with a programmable
// latency, core writes, and a host preload port. The core sees a one-cycle mem_ready pulse.
module cnn16_mem_unit #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] to_memory,
   input  logic              write_en,
   input  logic              read_en,
   output logic [DATA_W-1:0] from_memory,
   output logic              mem_ready,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              busy,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR      = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_mem_ready;
   logic                r_busy;
   logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;

   // Array writes only happen at an IDLE accept edge; host preload has priority over the core.
   assign w_mem_we    = (r_state == IDLE) && !rst && (host_we || write_en);
   assign w_mem_addr  = host_we ? host_addr : address;
   assign w_mem_wdata = host_we ? host_wdata : to_memory;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_addr      <= '0;
         r_rdata     <= '0;
         r_mem_ready <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_mem_ready <= 1'b0;
               if (host_we) begin
                  r_state <= IDLE;
               end else if (write_en) begin
                  r_state <= WR;
                  r_busy  <= 1'b1;
               end else if (read_en) begin
                  r_addr  <= address;
                  r_cnt   <= LAT_INIT;
                  r_state <= RD_WAIT;
                  r_busy  <= 1'b1;
               end
            end
            RD_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_rdata     <= r_mem[r_addr];
                  r_state     <= RESP;
                  r_mem_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            WR: begin
               r_state     <= RESP;
               r_mem_ready <= 1'b1;
            end
            RESP: begin
               r_state     <= IDLE;
               r_mem_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_mem_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign from_memory = r_rdata;
   assign mem_ready   = r_mem_ready;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cnn16_mem_unit.sv
// Directed bench for cnn16_mem_unit: default build (RD_LAT=2) plus an RD_LAT=1 build.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cnn16_mem_unit;
   localparam int AW = 12;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // default build
   logic [AW-1:0] address, host_addr;
   logic [DW-1:0] to_memory, host_wdata, from_memory;
   logic          write_en, read_en, host_we, mem_ready, busy;
   logic [1:0]    dbg_state;

   // RD_LAT=1 build
   logic [AW-1:0] address_b, host_addr_b;
   logic [DW-1:0] to_memory_b, host_wdata_b, from_memory_b;
   logic          write_en_b, read_en_b, host_we_b, mem_ready_b, busy_b;
   logic [1:0]    dbg_state_b;

   cnn16_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut (
      .clk(clk), .rst(rst), .address(address), .to_memory(to_memory),
      .write_en(write_en), .read_en(read_en), .from_memory(from_memory),
      .mem_ready(mem_ready), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .busy(busy), .o_dbg_state(dbg_state)
   );

   cnn16_mem_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .address(address_b), .to_memory(to_memory_b),
      .write_en(write_en_b), .read_en(read_en_b), .from_memory(from_memory_b),
      .mem_ready(mem_ready_b), .host_we(host_we_b), .host_addr(host_addr_b),
      .host_wdata(host_wdata_b), .busy(busy_b), .o_dbg_state(dbg_state_b)
   );

   // Issue one core request at the current falling edge; k = edges after accept until mem_ready.
   task automatic core_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic we, input logic re,
                           output int k, output logic [DW-1:0] data);
      address = a; to_memory = d; write_en = we; read_en = re;
      @(negedge clk);
      write_en = 1'b0; read_en = 1'b0;
      k = 0;
      while (!mem_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      data = from_memory;
      checks++;
      if (k >= 20) begin
         errors++;
         $display("FAIL req_timeout addr=%h got no mem_ready within %0d cycles", a, k);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", mem_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (from_memory !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", from_memory); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_host_preload();
      int k;
      logic [DW-1:0] d;
      host_we = 1'b1; host_addr = 12'h005; host_wdata = 16'h1234;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL host_busy got %b exp 0", busy); end
      host_addr = 12'hFFF; host_wdata = 16'hBEEF;
      @(negedge clk);
      host_we = 1'b0;
      core_req(12'h005, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (k !== 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", k); end
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL rd_005 got %h exp 1234", d); end
      checks++; if (mem_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_pulse_end ready=%b busy=%b exp 0 0", mem_ready, busy); end
      core_req(12'hFFF, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL rd_fff got %h exp beef", d); end
   endtask

   task automatic test_core_write();
      int k;
      logic [DW-1:0] d;
      core_req(12'h010, 16'hA5A5, 1'b1, 1'b0, k, d);
      checks++; if (k !== 1) begin errors++; $display("FAIL wr_latency got %0d exp 1", k); end
      checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL wr_keeps_rdata got %h exp beef", d); end
      // issued in the IDLE cycle right after the write's mem_ready
      core_req(12'h010, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'hA5A5) begin errors++; $display("FAIL rd_after_wr got %h exp a5a5", d); end
   endtask

   task automatic test_write_wins();
      int k, pulses;
      logic [DW-1:0] d;
      core_req(12'h020, 16'h0F0F, 1'b1, 1'b1, k, d);
      checks++; if (k !== 1) begin errors++; $display("FAIL both_latency got %0d exp 1", k); end
      checks++; if (d !== 16'hA5A5) begin errors++; $display("FAIL both_rdata got %h exp a5a5", d); end
      pulses = 0;
      repeat (4) begin
         if (mem_ready === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL both_extra_ready got %0d exp 0", pulses); end
      core_req(12'h020, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'h0F0F) begin errors++; $display("FAIL both_written got %h exp 0f0f", d); end
   endtask

   task automatic test_busy_ignore();
      int k, pulses;
      logic [DW-1:0] d, seen;
      address = 12'h005; read_en = 1'b1;
      @(negedge clk);
      host_we = 1'b1; host_addr = 12'h005; host_wdata = 16'hDEAD;
      address = 12'h010; read_en = 1'b1;
      @(negedge clk);
      host_we = 1'b0; read_en = 1'b0;
      pulses = 0; seen = 16'h0000;
      repeat (8) begin
         if (mem_ready === 1'b1) begin pulses++; seen = from_memory; end
         @(negedge clk);
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses got %0d exp 1", pulses); end
      checks++; if (seen !== 16'h1234) begin errors++; $display("FAIL busy_rdata got %h exp 1234", seen); end
      core_req(12'h005, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL busy_array got %h exp 1234", d); end
   endtask

   task automatic test_back_to_back();
      int t[$];
      int n;
      address = 12'hFFF; read_en = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (mem_ready === 1'b1) t.push_back(cyc);
      end
      read_en = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      checks++;
      if (t.size() < 2) begin
         errors++; $display("FAIL b2b_count got %0d exp >=2", t.size());
      end else if (t[1] - t[0] !== 4) begin
         errors++; $display("FAIL b2b_period got %0d exp 4", t[1] - t[0]);
      end
      checks++; if (from_memory !== 16'hBEEF) begin errors++; $display("FAIL b2b_rdata got %h exp beef", from_memory); end
   endtask

   task automatic test_reset_abort();
      int k, pulses;
      logic [DW-1:0] d;
      address = 12'h010; read_en = 1'b1;
      @(negedge clk);
      read_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (from_memory !== 16'h0000) begin errors++; $display("FAIL abort_rdata got %h exp 0000", from_memory); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (6) begin
         if (mem_ready === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_ready got %0d exp 0", pulses); end
      core_req(12'h005, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'h1234) begin errors++; $display("FAIL abort_preload got %h exp 1234", d); end
      // write aborted in WR must still be in the array
      address = 12'h030; to_memory = 16'h7777; write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      core_req(12'h030, 16'h0000, 1'b0, 1'b1, k, d);
      checks++; if (d !== 16'h7777) begin errors++; $display("FAIL abort_wr_persist got %h exp 7777", d); end
   endtask

   task automatic test_rdlat1();
      int k, n;
      int t[$];
      host_we_b = 1'b1; host_addr_b = 12'h005; host_wdata_b = 16'h1234;
      @(negedge clk);
      host_we_b = 1'b0;
      address_b = 12'h005; read_en_b = 1'b1;
      @(negedge clk);
      read_en_b = 1'b0;
      k = 0;
      while (!mem_ready_b && k < 20) begin @(negedge clk); k++; end
      checks++; if (k !== 1) begin errors++; $display("FAIL lat1_latency got %0d exp 1", k); end
      checks++; if (from_memory_b !== 16'h1234) begin errors++; $display("FAIL lat1_rdata got %h exp 1234", from_memory_b); end
      @(negedge clk);
      read_en_b = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (mem_ready_b === 1'b1) t.push_back(cyc);
      end
      read_en_b = 1'b0;
      n = 0;
      while (busy_b === 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (t.size() < 3) begin
         errors++; $display("FAIL lat1_b2b_count got %0d exp >=3", t.size());
      end else if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
         errors++; $display("FAIL lat1_b2b_period got %0d,%0d exp 3,3", t[1] - t[0], t[2] - t[1]);
      end
   endtask

   initial begin
      rst = 1'b1;
      address = '0; to_memory = '0; write_en = 1'b0; read_en = 1'b0;
      host_we = 1'b0; host_addr = '0; host_wdata = '0;
      address_b = '0; to_memory_b = '0; write_en_b = 1'b0; read_en_b = 1'b0;
      host_we_b = 1'b0; host_addr_b = '0; host_wdata_b = '0;
      test_reset();
      test_host_preload();
      test_core_write();
      test_write_wins();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      test_rdlat1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
